// File: rtl/sha1_stream_frontend.sv
// sha1_stream_frontend: splits a byte stream into SHA-1 padded 16-word blocks and holds the returned digest.
// Define SHA1_FE_OVF_EN to add the sticky len_ovf byte-counter overflow output.
module sha1_stream_frontend #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   t_data,
    input  logic [DATA_W/8-1:0] t_keep,
    input  logic                t_valid,
    input  logic                t_last,
    output logic                t_ready,
    output logic [31:0]         core_data,
    output logic                core_valid,
    input  logic                core_ready,
    output logic                core_first,
    output logic                core_blk_end,
    input  logic                core_done,
    input  logic [159:0]        core_digest,
    output logic [159:0]        hash_out,
    output logic                hash_valid,
    input  logic                hash_ready
`ifdef SHA1_FE_OVF_EN
    ,
    output logic                len_ovf
`endif
);
    localparam int NB = DATA_W / 8;
    localparam int NW = DATA_W / 32;
    localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, PAD = 3'd2, ZERO = 3'd3,
                           LEN_HI = 3'd4, LEN_LO = 3'd5, WAIT_DIG = 3'd6, OUT = 3'd7;

    logic [2:0]        state;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        buf_cnt;
    logic [1:0]        ld_words;
    logic              buf_last;
    logic              buf_pad;
    logic [3:0]        widx;
    logic              first_blk;
    logic [LEN_W-1:0]  byte_cnt;
    logic [LEN_W-1:0]  byte_sum;
    logic [3:0]        keep_n;
    logic [3:0]        beat_bytes;
    logic [63:0]       bit_len;
    logic              beat_acc;
    logic              word_acc;
    logic              gen_state;
    logic [2:0]        after_pad;

    // Last beat: bytes past n are zeroed and a partial word carries the 0x80 pad byte.
    always_comb begin
        keep_n = '0;
        for (int i = 0; i < NB; i++)
            keep_n = keep_n + {3'b000, t_keep[i]};
        ld_data = '0;
        for (int i = 0; i < NB; i++)
            ld_data[DATA_W-1-8*i -: 8] = (!t_last || 4'(i) < keep_n) ? t_data[DATA_W-1-8*i -: 8] :
                                         (4'(i) == keep_n && keep_n[1:0] != 2'd0) ? 8'h80 : 8'h00;
    end

    assign ld_words   = t_last ? 2'((keep_n + 4'd3) >> 2) : 2'(NW);
    assign beat_bytes = t_last ? keep_n : 4'(NB);
    assign bit_len    = {{(61-LEN_W){1'b0}}, byte_cnt, 3'b000};
    assign gen_state  = state == PAD || state == ZERO || state == LEN_HI || state == LEN_LO;
    assign core_valid = buf_cnt != 2'd0 || gen_state;
    assign core_data  = buf_cnt != 2'd0 ? buf_data[DATA_W-1 -: 32] :
                        state == LEN_HI ? bit_len[63:32] :
                        state == LEN_LO ? bit_len[31:0] :
                        state == PAD    ? 32'h8000_0000 : 32'h0;
    assign core_first   = core_valid && first_blk && widx == 4'd0;
    assign core_blk_end = core_valid && widx == 4'd15;
    assign word_acc   = core_valid && core_ready;
    assign t_ready    = !rst && (state == IDLE || state == DATA) && !buf_last &&
                        (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && core_ready));
    assign beat_acc   = t_valid && t_ready;
    // Zero-fill stops at index 13 so the length lands in words 14/15.
    assign after_pad  = widx == 4'd13 ? LEN_HI : ZERO;

`ifdef SHA1_FE_OVF_EN
    logic byte_carry;
    assign {byte_carry, byte_sum} = {1'b0, byte_cnt} + {{(LEN_W-3){1'b0}}, beat_bytes};
`else
    assign byte_sum = byte_cnt + {{(LEN_W-4){1'b0}}, beat_bytes};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            buf_data   <= '0;
            buf_cnt    <= 2'd0;
            buf_last   <= 1'b0;
            buf_pad    <= 1'b0;
            widx       <= 4'd0;
            first_blk  <= 1'b1;
            byte_cnt   <= '0;
            hash_out   <= '0;
            hash_valid <= 1'b0;
`ifdef SHA1_FE_OVF_EN
            len_ovf    <= 1'b0;
`endif
        end else begin
            if (word_acc) begin
                widx <= widx + 4'd1;
                if (widx == 4'd15)
                    first_blk <= 1'b0;
            end
            if (beat_acc) begin
                buf_data <= ld_data;
                buf_cnt  <= ld_words;
                buf_last <= t_last && ld_words != 2'd0;
                buf_pad  <= t_last && keep_n[1:0] != 2'd0;
                byte_cnt <= byte_sum;
                state    <= (t_last && ld_words == 2'd0) ? PAD : DATA;
`ifdef SHA1_FE_OVF_EN
                if (byte_carry)
                    len_ovf <= 1'b1;
`endif
            end else if (buf_cnt != 2'd0 && core_ready) begin
                buf_data <= buf_data << 32;
                buf_cnt  <= buf_cnt - 2'd1;
                if (buf_cnt == 2'd1 && buf_last) begin
                    buf_last <= 1'b0;
                    state    <= buf_pad ? after_pad : PAD;
                end
            end else if (word_acc && gen_state) begin
                state <= (state == PAD || state == ZERO) ? after_pad : state == LEN_HI ? LEN_LO : WAIT_DIG;
            end else if (state == WAIT_DIG && core_done) begin
                hash_out   <= core_digest;
                hash_valid <= 1'b1;
                state      <= OUT;
            end else if (state == OUT && hash_ready) begin
                hash_valid <= 1'b0;
                state      <= IDLE;
                byte_cnt   <= '0;
                first_blk  <= 1'b1;
`ifdef SHA1_FE_OVF_EN
                len_ovf    <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: doc/sha1_stream_frontend.md
Name: sha1_stream_frontend

Overview:
Parametrised successor to the current SHA-1 top-level glue. Accepts a byte-granular message stream at DATA_W bits per beat with byte enables, splits it into 32-bit big-endian words, and appends SHA-1 padding and the 64-bit length. It feeds 16-word blocks to the SHA-1 core over a valid/ready word interface, then captures the digest and holds it in a valid/ready output register, so back-to-back messages need no external sequencing.

Parameters:
DATA_W, 32, input beat width; legal values 32 or 64.
LEN_W, 32, byte-length counter width; bit length = {bytes,3'b000} zero-extended to 64.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
t_data  in  DATA_W  message beat; byte lane 0 = MSBs
t_keep  in  DATA_W/8  byte enables, sampled on t_last beat only; must be MSB-contiguous
t_valid  in  1  beat valid
t_last  in  1  final beat of message
t_ready  out  1  beat accepted when t_valid&&t_ready
core_data  out  32  word to SHA-1 core
core_valid  out  1  core_data valid
core_ready  in  1  core accepts word
core_first  out  1  with first word of a message; core reloads initial H
core_blk_end  out  1  with word 15 of each block
core_done  in  1  one-cycle pulse, core_digest valid
core_digest  in  160  final digest
hash_out  out  160  captured digest
hash_valid  out  1  hash_out valid
hash_ready  in  1  consumer accepts digest

Behaviour:
- Reset (async, any state): state=IDLE, t_ready=0 during reset then 1, core_valid=0, core_first=0, core_blk_end=0, hash_valid=0, hash_out=0, byte count=0, word index=0. Reset mid-message discards all partial state; core is not notified.
- States: IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO, WAIT_DIG, OUT.
- IDLE/DATA: t_ready=1 only when beat buffer empty, or its last word is being accepted by core (core_valid&&core_ready). An accepted beat loads the buffer; words are emitted MSW first, core_valid asserted the cycle after acceptance (1-cycle latency).
- Non-last beats: all lanes valid, t_keep ignored. Last beat: n = popcount(t_keep). Words with no valid bytes are not emitted as data.
- Partial final word (k=1..3 valid bytes): data bytes, byte k=0x80, remainder 0x00, counted as pad word. If final word full (or n=0), PAD emits 0x80000000.
- After the pad byte word: if word index <=13, ZERO fills to index 13; else ZERO fills to 15, then a fresh block zeros 0..13. LEN_HI (index 14) = bit length[63:32], LEN_LO (index 15) = bit length[31:0].
- Word index is 4-bit and wraps 15->0; core_blk_end=1 whenever index=15. core_first=1 only on index 0 of block 0.
- Word holds stable while core_valid&&!core_ready; no word dropped or repeated.
- After LEN_LO accepted -> WAIT_DIG; t_ready=0. core_done in WAIT_DIG captures core_digest into hash_out, hash_valid=1 next cycle, -> OUT. core_done in any other state is ignored.
- OUT: hash_valid held until hash_ready; on handshake hash_valid=0 and state=IDLE with t_ready=1 next cycle. hash_out retains its value until the next capture.
- Byte counter adds n per accepted last beat (DATA_W/8 otherwise); wraps mod 2^LEN_W.
- Empty message (t_last, t_keep=0): one block, 0x80000000, 14 zero words, LEN_LO=0.

Optional Feature:
SHA1_FE_OVF_EN: when defined, adds output port len_ovf (1 bit). It is a sticky flag set when the byte counter carries out of LEN_W and cleared on the OUT handshake or on reset; the digest is still produced. When undefined, the port is absent and the counter wraps silently.

Test Plan:
- DATA_W=32, "abc": beat 0x61626300, keep 4'b1110, last -> words 0x61626380, 13x0, 0x0, 0x00000018; with real core hash_out=a9993e364706816aba3e25717850c26c9cd0d89d.
- Empty message, keep 0 -> 0x80000000, 14x0, LEN_LO 0x0, core_first on word 0; hash da39a3ee5e6b4b0d3255bfef95601890afd80709.
- 56-byte message -> 14 data words, 0x80000000, 0x0, then block 2: 14x0, 0x0, 0x000001C0; two core_blk_end pulses.
- DATA_W=64, 13 bytes, last keep 8'b11111000 -> 3 data words, word 3 = {byte12,0x80,0x00,0x00}, LEN_LO 0x68.
- core_ready toggling 1-0 every cycle and hash_ready held low 20 cycles -> word sequence identical to stall-free case, t_ready=0 until hash handshake.
- rst pulse mid-message after 5 words -> all outputs zero; next "abc" produces correct sequence with core_first=1.
